wb_sram: RTL
============

# wb_sram

Parametrised on-chip memory slave on the system Wishbone bus, successor to the read-only boot ROM block. It provides word-wide synchronous storage with byte-lane writes and registered-feedback bursts, covering the incrementing burst and the 4/8/16-beat wrap bursts. Instantiated once per memory region behind the bus interconnect. A read-only mode lets the same block serve as a preloaded ROM that flags writes as bus errors.

## Interface
- ADDR_BITS, 12: device byte-address width; depth is 2^(ADDR_BITS-2) words.
- WB_ADDR_BITS, 32: Wishbone address width.
- HIGH_ADDR, 20'h00000: required value of wbs_addr_i[WB_ADDR_BITS-1:ADDR_BITS] for select.
- WORD_BYTES, 4: bytes per word; WORD_BITS = 8*WORD_BYTES.
- READ_ONLY, 0: 1 = writes ignored and answered with err.
- INIT_FILE, "": hex image loaded at elaboration when non-empty; otherwise contents are undefined.
- wbs_clk_i  in  1  bus clock; all logic on its rising edge.
- wbs_rst_i  in  1  asynchronous, active-high reset.
- wbs_cyc_i, wbs_stb_i  in  1 each  Wishbone cycle and strobe.
- wbs_addr_i  in  WB_ADDR_BITS-2 ([WB_ADDR_BITS-1:2])  word address.
- wbs_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
- wbs_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wbs_sel_i  in  WORD_BYTES  byte-lane enables.
- wbs_we_i  in  1  write enable.
- wbs_data_i  in  WORD_BITS  write data.
- wbs_data_o  out  WORD_BITS  read data, registered.
- wbs_ack_o  out  1  transfer acknowledge, registered.
- wbs_err_o  out  1  error acknowledge, registered.

## Operation
- cs = cyc & stb & (high address bits == HIGH_ADDR). burst = cs & (cti == 010); cti 000 or 111 is treated as non-burst.
- Any other cti value (001, 011..110) is treated as classic.
- Response: at each edge with cs, term = ack|err. If cs & term & ~burst, term drops to 0. Otherwise term is 1.
- A term asserted while cs is present is ack, except when READ_ONLY=1 & we: then it is err, and ack stays 0.
- Without cs, ack and err are 0.
- Write: at an edge with cs & ack & we & ~READ_ONLY, each byte lane i with sel[i]=1 is written at wbs_addr_i. Other lanes are unchanged.
- Read address: rd_addr = next(wbs_addr_i) when ack & burst. Otherwise rd_addr = wbs_addr_i. wbs_data_o <= mem[rd_addr] every cycle.
- next() for linear: the device word address + 1, wrapping modulo the depth.
- next() for wrap 2^k (k = 2, 3, 4 for bte 01, 10, 11): the low k bits increment modulo 2^k; the upper bits are held.
- Reads are not byte-masked; sel is ignored for reads.
- Read-after-write to the same word within one burst is not supported; the prefetch returns the old data.

## Timing
- Reset values: ack_o=0, err_o=0, data_o=0. Memory contents are preserved.
- Reset asserted mid-burst forces ack/err to 0 immediately (asynchronous). The first response after release is 1 cycle after the next cs.
- Classic read or write: stb at edge N produces ack high during cycle N+1, with data valid alongside for reads. ack drops at N+2 even if stb is still high. Throughput is 1 transfer per 2 cycles.
- Burst: first ack 1 cycle after stb. After that, ack is high every cycle while cti=010, with each beat's data prefetched from next(addr).
- The beat with cti=111 is acked. ack then drops on the following edge.
- A master deasserting stb mid-burst (wait state) causes ack to drop in the next cycle. A re-asserted stb costs 1 cycle before ack returns.

## Test plan
- Classic read: preload mem[5]=32'hDEADBEEF, read addr 5 (cti 000) -> ack 1 cycle later, data 32'hDEADBEEF, ack low on the following cycle.
- Byte write: mem[3]=32'h11223344, write 32'hAABBCCDD with sel=0101 -> mem[3] becomes 32'h11BB33DD, checked by a read-back.
- Linear burst from word 0x3FE with depth 1024 and mem[i]=i, 4 beats ending cti 111 -> data 0x3FE, 0x3FF, 0x000, 0x001 on consecutive ack cycles; ack low after the last beat.
- Wrap8 burst starting at word 0x0D, 8 beats -> addresses 0x0D, 0x0E, 0x0F, 0x08 .. 0x0C with data matching; no gap in ack.
- READ_ONLY=1: write 32'h0 to addr 2 -> err 1 cycle later, ack stays 0, mem[2] unchanged. Also: a non-matching high address gives no ack and no err.
- Assert wbs_rst_i in the middle of the 3rd beat of a linear burst -> ack, err and data go to 0 at once. Memory holds the earlier written words. A new classic read after release acks in 1 cycle.

Source files
------------

// File: rtl/wb_sram.sv
// wb_sram: word-wide Wishbone memory slave with byte-lane writes,
// registered-feedback bursts (linear, wrap4/8/16) and an optional read-only
// mode. In read-only mode, writes are answered with err instead of ack.
module wb_sram #(
  parameter int                                ADDR_BITS    = 12,
  parameter int                                WB_ADDR_BITS = 32,
  parameter logic [WB_ADDR_BITS-ADDR_BITS-1:0] HIGH_ADDR    = 20'h00000,
  parameter int                                WORD_BYTES   = 4,
  parameter bit                                READ_ONLY    = 1'b0,
  parameter string                             INIT_FILE    = ""
) (
  input  logic                      wbs_clk_i,
  input  logic                      wbs_rst_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic [WB_ADDR_BITS-1:2]   wbs_addr_i,
  input  logic [2:0]                wbs_cti_i,
  input  logic [1:0]                wbs_bte_i,
  input  logic [WORD_BYTES-1:0]     wbs_sel_i,
  input  logic                      wbs_we_i,
  input  logic [8*WORD_BYTES-1:0]   wbs_data_i,
  output logic [8*WORD_BYTES-1:0]   wbs_data_o,
  output logic                      wbs_ack_o,
  output logic                      wbs_err_o
);

  localparam int WORD_BITS = 8 * WORD_BYTES;
  localparam int AW        = ADDR_BITS - 2;
  localparam int DEPTH     = 1 << AW;

  logic [WORD_BITS-1:0] mem [DEPTH];

  logic          cs;
  logic          burst;
  logic          ro_write;
  logic [AW-1:0] word;
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] next_word;
  logic [AW-1:0] rd_word;

  assign word     = wbs_addr_i[ADDR_BITS-1:2];
  assign cs       = wbs_cyc_i & wbs_stb_i &
                    (wbs_addr_i[WB_ADDR_BITS-1:ADDR_BITS] == HIGH_ADDR);
  // Only cti 010 continues a burst; every other code behaves as classic.
  assign burst    = cs & (wbs_cti_i == 3'b010);
  assign ro_write = READ_ONLY & wbs_we_i;

  // Address bits that advance on a burst beat; the rest are held.
  always_comb begin
    wrap_mask = '1;
    case (wbs_bte_i)
      2'b01:   wrap_mask = AW'(4'h3);
      2'b10:   wrap_mask = AW'(4'h7);
      2'b11:   wrap_mask = AW'(4'hF);
      default: wrap_mask = '1;
    endcase
  end

  // During an acked burst beat, prefetch the following word so the next
  // beat's data is ready without a wait state.
  assign next_word = (word & ~wrap_mask) | ((word + AW'(1)) & wrap_mask);
  assign rd_word   = (wbs_ack_o & burst) ? next_word : word;

  // Response generation: a classic cycle acks once and then drops, while a
  // burst keeps the terminating signal high every cycle.
  always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
    if (wbs_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
    end else if (!cs) begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
    end else if ((wbs_ack_o | wbs_err_o) & ~burst) begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
    end else begin
      wbs_ack_o <= ~ro_write;
      wbs_err_o <= ro_write;
    end
  end

  // Registered read port, refreshed every cycle from the selected word.
  always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
    if (wbs_rst_i) wbs_data_o <= '0;
    else           wbs_data_o <= mem[rd_word];
  end

  if (!READ_ONLY) begin : g_write
    // Byte-lane write, committed on the edge that completes an acked beat.
    always_ff @(posedge wbs_clk_i) begin
      if (cs & wbs_ack_o & wbs_we_i) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
          if (wbs_sel_i[i]) mem[word][8*i +: 8] <= wbs_data_i[8*i +: 8];
        end
      end
    end
  end

endmodule
